cache_sim: RTL and testbench
============================

Name: cache_sim

Overview:
- Behavioural, cycle-driven set-associative cache model.
- Takes one memory access (read/write plus address) every clock.
- Tracks tag/valid/dirty state with true-LRU replacement and a write-back, write-allocate policy.
- Accumulates access, hit, miss, eviction and writeback statistics; the verification bench reads these hierarchically. There are no data outputs.

Parameters:
- SETS, 16, number of sets (power of two, ≥2)
- ASSOC, 2, ways per set (power of two, 1..8)
- LINESIZE, 16, bytes per line (power of two, ≥2)
- ADDRESS_SIZE, 16, address width in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- rw  input  1  access type: 0 = read, 1 = write
- address  input  ADDRESS_SIZE  byte address of the access

Behaviour:
- Derived constants, visible by these exact names:
  - bsWidth = clog2(LINESIZE)
  - indexWidth = clog2(SETS)
  - tagWidth = ADDRESS_SIZE - bsWidth - indexWidth
  - Defaults give 4 / 4 / 8.
- Address split: offset = address[bsWidth-1:0]; cache_index = next indexWidth bits; cache_tag = top tagWidth bits. Both are continuous (combinational) signals.
- Storage: cache[way][set], with ways numbered 1..ASSOC.
  - Entry layout: [tagWidth+2:3] tag, [2] reserved (0), [1] dirty, [0] valid.
  - Separate LRU age per line: clog2(ASSOC) bits, minimum 1; 0 = MRU, ASSOC-1 = LRU.
- Reset (clk edge with reset=1):
  - Clears all valid, dirty and tag bits.
  - Sets ages to way-ordered 0..ASSOC-1; way 1 starts as MRU, way ASSOC as LRU.
  - Zeroes all counters. No access is counted in that cycle.
- Every rising edge with reset=0 is exactly one access. Latency is 1 cycle: state and counters reflect the access immediately after the edge.
- Counters are 32-bit unsigned and wrap silently: cAccesses, cReads, cWrites, cHits, cMisses, numEvictions, numWritebacks.
- Every access increments cAccesses, plus cReads (rw=0) or cWrites (rw=1).
- Hit (some valid way's tag == cache_tag):
  - cHits++.
  - That way becomes MRU; lines younger than its old age age by 1.
  - A write sets its dirty bit.
- Miss:
  - cMisses++.
  - Victim selection: lowest-numbered invalid way if any (invalid_flag=1, i_LRU_* report it). Otherwise the way with age ASSOC-1 (LRU_set/LRU_address report it).
  - Evicting a valid line: numEvictions++. If that line is dirty, numWritebacks++ as well.
  - Evicted line address is pushed onto queue LRU_evict; LRU_evict[$] is the most recent.
  - Fill victim with tag and valid=1; dirty = rw.
  - Victim becomes MRU and ages update as on a hit.
- LRU_queue: debug queue holding way numbers of the current set, ordered LRU first. Rebuilt after every access.
- Debug signals, all post-edge:
  - invalid_flag
  - LRU_address, i_LRU_address: full line address {tag,index,0s} of the victim
  - LRU_set, i_LRU_set: victim way number
- Ratios (real, percent), recomputed after every access:
  - hitRatio = 100*cHits/cAccesses
  - missRatio = 100*cMisses/cAccesses
  - Both are 0.0 while cAccesses = 0.
- Accesses to different offsets within a line map to the same line.
- Simultaneous reset and access: reset wins and the access is dropped.
- Reset mid-stream: discards all contents without counting writebacks.

Decomposition:
- Package cache_sim_pkg holds:
  - u16/u32/u64 typedefs
  - rw encoding constants (READ=0, WRITE=1)
  - Entry field offsets (VALID=0, DIRTY=1, TAG_LSB=3)
  - Helper function for line address
- One natural sub-module: cache_sim_lru, which holds per-set ages, does victim select and does the MRU update, parameterised by SETS and ASSOC. Tag array and counters stay in the top.

Test Plan (defaults; 0x1234 → tag 0x12, index 3, offset 4):
- reset, then read 0x1234 → miss, invalid_flag=1, fills way 1. Counters: cAccesses=1, cReads=1, cMisses=1, numEvictions=0, missRatio=100.00.
- Then read 0x1238 → hit on way 1: cHits=1, hitRatio=50.00, missRatio=50.00.
- Then write 0x2234 → miss into way 2 with dirty=1, cWrites=1. Then read 0x3234 → evicts way 1 (tag 0x12): numEvictions=1, numWritebacks=0, LRU_evict[$]=0x1230.
- Then read 0x4234 → evicts dirty tag 0x22 in way 2: numEvictions=2, numWritebacks=1, LRU_evict[$]=0x2230.
- Write 0x5670 twice then read 0x567F → 1 miss, 2 hits, line dirty, no evictions. Reads to index 0 (0x0000, 0x1000, 0x2000) are unaffected by index 7 state.
- Mid-stream reset after the above → all counters 0, ratios 0.0. Next read 0x3234 misses with invalid_flag=1 and numWritebacks=0.

Source files
------------

// File: rtl/cache_sim_pkg.sv
// cache_sim shared types and helpers.
// Entry field offsets, rw encoding and line-address helper.
package cache_sim_pkg;

  typedef logic [15:0] u16;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int VALID   = 0;
  localparam int DIRTY   = 1;
  localparam int TAG_LSB = 3;

  // Rebuild the base byte address of a line from its tag and set index.
  function automatic u32 line_addr(
    input u32 tag,
    input u32 idx,
    input int bs_w,
    input int idx_w
  );
    return (tag << (bs_w + idx_w)) | (idx << bs_w);
  endfunction

endpackage

// File: rtl/cache_sim_lru.sv
// cache_sim true-LRU age tracking.
// Per-set ages, victim choice and MRU promotion.
module cache_sim_lru
  import cache_sim_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int ASSOC = 2,
  parameter int IW    = (SETS > 1) ? $clog2(SETS) : 1,
  parameter int AW    = (ASSOC > 1) ? $clog2(ASSOC) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [IW-1:0]              set_idx,
  input  logic [ASSOC-1:0]           valid_vec,
  input  logic                       hit,
  input  logic [AW-1:0]              hit_way,
  output logic                       inv_flag,
  output logic [AW-1:0]              inv_way,
  output logic [AW-1:0]              lru_way,
  output logic [AW-1:0]              victim,
  output logic [ASSOC-1:0][AW-1:0]   age_next
);

  logic [AW-1:0] age_q [SETS][ASSOC];
  logic [AW-1:0] age_d [SETS][ASSOC];
  logic [AW-1:0] touch;
  logic [AW-1:0] t_age;

  // Victim: lowest invalid way first, else the oldest way.
  always_comb begin
    inv_flag = 1'b0;
    inv_way  = '0;
    lru_way  = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!valid_vec[w]) begin
        inv_flag = 1'b1;
        inv_way  = AW'(w);
      end
      if (age_q[set_idx][w] == AW'(ASSOC - 1))
        lru_way = AW'(w);
    end
    victim = inv_flag ? inv_way : lru_way;
  end

  // Touched way becomes MRU; younger lines age by one.
  always_comb begin
    touch = hit ? hit_way : victim;
    t_age = age_q[set_idx][touch];
    for (int w = 0; w < ASSOC; w++) begin
      age_next[w] = age_q[set_idx][w];
      if (AW'(w) == touch)
        age_next[w] = '0;
      else if (age_q[set_idx][w] < t_age)
        age_next[w] = age_q[set_idx][w] + AW'(1);
    end
  end

  // Next-state ages: way-ordered on reset, else the touched set.
  always_comb begin
    age_d = age_q;
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < ASSOC; w++)
          age_d[s][w] = AW'(w);
    end else if (en) begin
      for (int w = 0; w < ASSOC; w++)
        age_d[set_idx][w] = age_next[w];
    end
  end

  // Age storage.
  always_ff @(posedge clk) begin
    age_q <= age_d;
  end

endmodule

// File: rtl/cache_sim.sv
// cache_sim: cycle-driven set-associative cache model.
// Write-back, write-allocate, true LRU, with statistics.
module cache_sim
  import cache_sim_pkg::*;
#(
  parameter int SETS         = 16,
  parameter int ASSOC        = 2,
  parameter int LINESIZE     = 16,
  parameter int ADDRESS_SIZE = 16
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    rw,
  input logic [ADDRESS_SIZE-1:0] address
);

  localparam int bsWidth    = $clog2(LINESIZE);
  localparam int indexWidth = $clog2(SETS);
  localparam int tagWidth   = ADDRESS_SIZE - bsWidth - indexWidth;
  localparam int AW = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int SW = $clog2(ASSOC + 1);
  localparam int EW = tagWidth + 3;

  typedef logic [ADDRESS_SIZE-1:0] addr_t;
  typedef logic [EW-1:0]           entry_t;
  typedef logic [SW-1:0]           way_t;

  logic [bsWidth-1:0]    offset;
  logic [indexWidth-1:0] cache_index;
  logic [tagWidth-1:0]   cache_tag;

  assign offset      = address[bsWidth-1:0];
  assign cache_index = address[bsWidth +: indexWidth];
  assign cache_tag   = address[ADDRESS_SIZE-1 -: tagWidth];

  entry_t cache   [1:ASSOC][SETS];
  entry_t cache_d [1:ASSOC][SETS];

  logic [31:0] cAccesses, cReads, cWrites, cHits, cMisses;
  logic [31:0] numEvictions, numWritebacks;
  logic [31:0] cAccesses_d, cReads_d, cWrites_d, cHits_d;
  logic [31:0] cMisses_d, numEvictions_d, numWritebacks_d;

  logic  invalid_flag, invalid_flag_d;
  addr_t LRU_address, LRU_address_d;
  addr_t i_LRU_address, i_LRU_address_d;
  way_t  LRU_set, LRU_set_d;
  way_t  i_LRU_set, i_LRU_set_d;

  addr_t LRU_evict [$];
  way_t  LRU_queue [$];

  real hitRatio;
  real missRatio;

  logic                     hit;
  logic [AW-1:0]            hit_way;
  logic [ASSOC-1:0]         valid_vec;
  logic                     inv_flag;
  logic [AW-1:0]            inv_way;
  logic [AW-1:0]            lru_way;
  logic [AW-1:0]            victim;
  logic [ASSOC-1:0][AW-1:0] age_next;
  entry_t                   vic_e;
  addr_t                    vic_addr;
  logic                     evict;
  logic                     wback;
  u32                       la;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int w = 0; w < ASSOC; w++) begin
      valid_vec[w] = cache[w+1][cache_index][VALID];
      if (valid_vec[w] &&
          cache[w+1][cache_index][EW-1:TAG_LSB] == cache_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  cache_sim_lru #(
    .SETS  (SETS),
    .ASSOC (ASSOC),
    .IW    (indexWidth),
    .AW    (AW)
  ) u_lru (
    .clk       (clk),
    .reset     (reset),
    .en        (!reset),
    .set_idx   (cache_index),
    .valid_vec (valid_vec),
    .hit       (hit),
    .hit_way   (hit_way),
    .inv_flag  (inv_flag),
    .inv_way   (inv_way),
    .lru_way   (lru_way),
    .victim    (victim),
    .age_next  (age_next)
  );

  // Victim line details; eviction only when a valid line is displaced.
  always_comb begin
    vic_e = cache[int'(victim)+1][cache_index];
    la = line_addr(u32'(vic_e[EW-1:TAG_LSB]), u32'(cache_index),
                   bsWidth, indexWidth);
    vic_addr = la[ADDRESS_SIZE-1:0];
    evict = !reset && !hit && vic_e[VALID];
    wback = evict && vic_e[DIRTY];
  end

  // Tag array update: hit marks dirty on write, miss fills victim.
  always_comb begin
    cache_d = cache;
    if (reset) begin
      for (int w = 1; w <= ASSOC; w++)
        for (int s = 0; s < SETS; s++)
          cache_d[w][s] = '0;
    end else if (hit) begin
      if (rw == WRITE)
        cache_d[int'(hit_way)+1][cache_index][DIRTY] = 1'b1;
    end else begin
      cache_d[int'(victim)+1][cache_index] = {cache_tag, 1'b0, rw, 1'b1};
    end
  end

  // Statistic and debug next-state for the current access.
  always_comb begin
    cAccesses_d     = cAccesses + 32'd1;
    cReads_d        = cReads + 32'(rw == READ);
    cWrites_d       = cWrites + 32'(rw == WRITE);
    cHits_d         = cHits + 32'(hit);
    cMisses_d       = cMisses + 32'(!hit);
    numEvictions_d  = numEvictions + 32'(evict);
    numWritebacks_d = numWritebacks + 32'(wback);
    invalid_flag_d  = !hit && inv_flag;
    LRU_address_d   = LRU_address;
    LRU_set_d       = LRU_set;
    i_LRU_address_d = i_LRU_address;
    i_LRU_set_d     = i_LRU_set;
    if (!hit && inv_flag) begin
      i_LRU_address_d = vic_addr;
      i_LRU_set_d     = SW'(int'(inv_way) + 1);
    end else if (!hit) begin
      LRU_address_d = vic_addr;
      LRU_set_d     = SW'(int'(lru_way) + 1);
    end
  end

  // Registered array, counters and debug state.
  always_ff @(posedge clk) begin
    cache <= cache_d;
    if (reset) begin
      cAccesses     <= '0;
      cReads        <= '0;
      cWrites       <= '0;
      cHits         <= '0;
      cMisses       <= '0;
      numEvictions  <= '0;
      numWritebacks <= '0;
      invalid_flag  <= 1'b0;
      LRU_address   <= '0;
      LRU_set       <= '0;
      i_LRU_address <= '0;
      i_LRU_set     <= '0;
    end else begin
      cAccesses     <= cAccesses_d;
      cReads        <= cReads_d;
      cWrites       <= cWrites_d;
      cHits         <= cHits_d;
      cMisses       <= cMisses_d;
      numEvictions  <= numEvictions_d;
      numWritebacks <= numWritebacks_d;
      invalid_flag  <= invalid_flag_d;
      LRU_address   <= LRU_address_d;
      LRU_set       <= LRU_set_d;
      i_LRU_address <= i_LRU_address_d;
      i_LRU_set     <= i_LRU_set_d;
    end
  end

  // Eviction history and LRU-first way order of the accessed set.
  always_ff @(posedge clk) begin
    if (reset) begin
      LRU_evict.delete();
      LRU_queue.delete();
    end else begin
      if (evict)
        LRU_evict.push_back(vic_addr);
      LRU_queue.delete();
      for (int a = ASSOC - 1; a >= 0; a--)
        for (int w = 0; w < ASSOC; w++)
          if (age_next[w] == AW'(a))
            LRU_queue.push_back(SW'(w + 1));
    end
  end

  // Percent ratios, zero until the first access.
  always_comb begin
    hitRatio  = 0.0;
    missRatio = 0.0;
    if (cAccesses != 32'd0) begin
      hitRatio  = 100.0 * real'(cHits) / real'(cAccesses);
      missRatio = 100.0 * real'(cMisses) / real'(cAccesses);
    end
  end

endmodule

// File: tb/tb_cache_sim.sv
// tb_cache_sim: directed scoreboard bench for cache_sim.
// Driver queues expected state; monitor compares after each edge.
module tb_cache_sim;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rw = 1'b0;
  logic [15:0] address = 16'h0;

  always #5 clk = ~clk;

  cache_sim #(
    .SETS         (16),
    .ASSOC        (2),
    .LINESIZE     (16),
    .ADDRESS_SIZE (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rw      (rw),
    .address (address)
  );

  typedef struct {
    string       name;
    int          acc, rd, wr, hit, miss, ev, wb;
    int          inv;
    int          hr, mr;
    int          ev_chk;
    logic [15:0] ev_addr;
    int          lru_set;
    int          d_way, d_idx, d_val;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(string n, int acc, int rd, int wr,
                              int h, int m, int ev, int wb, int inv,
                              int hr, int mr);
    exp_t e;
    e.name = n; e.acc = acc; e.rd = rd; e.wr = wr;
    e.hit = h; e.miss = m; e.ev = ev; e.wb = wb; e.inv = inv;
    e.hr = hr; e.mr = mr;
    e.ev_chk = 0; e.ev_addr = '0; e.lru_set = 0;
    e.d_way = 0; e.d_idx = 0; e.d_val = 0;
    return e;
  endfunction

  task automatic cmp(string n, string f, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s.%s got %0d want %0d", n, f, act, expv);
    end
  endtask

  task automatic apply(logic w, logic [15:0] a, exp_t e);
    @(negedge clk);
    reset = 1'b0;
    rw = w;
    address = a;
    sb.push_back(e);
  endtask

  task automatic do_reset(exp_t e);
    @(negedge clk);
    reset = 1'b1;
    rw = 1'b1;
    address = 16'h1234;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.name, "cAccesses", int'(dut.cAccesses), e.acc);
        cmp(e.name, "cReads", int'(dut.cReads), e.rd);
        cmp(e.name, "cWrites", int'(dut.cWrites), e.wr);
        cmp(e.name, "cHits", int'(dut.cHits), e.hit);
        cmp(e.name, "cMisses", int'(dut.cMisses), e.miss);
        cmp(e.name, "numEvictions", int'(dut.numEvictions), e.ev);
        cmp(e.name, "numWritebacks", int'(dut.numWritebacks), e.wb);
        cmp(e.name, "invalid_flag", int'(dut.invalid_flag), e.inv);
        cmp(e.name, "hitRatio_x100",
            $rtoi(dut.hitRatio * 100.0 + 0.5), e.hr);
        cmp(e.name, "missRatio_x100",
            $rtoi(dut.missRatio * 100.0 + 0.5), e.mr);
        if (e.ev_chk != 0) begin
          if (dut.LRU_evict.size() == 0)
            cmp(e.name, "LRU_evict_size", 0, 1);
          else
            cmp(e.name, "LRU_evict_last",
                int'(dut.LRU_evict[$]), int'(e.ev_addr));
        end
        if (e.lru_set != 0)
          cmp(e.name, "LRU_set", int'(dut.LRU_set), e.lru_set);
        if (e.d_way != 0)
          cmp(e.name, "dirty",
              int'(dut.cache[e.d_way][e.d_idx][1]), e.d_val);
      end
    end
  end

  initial begin : driver
    exp_t e;
    int waited;

    e = mk("reset0", 0,0,0,0,0,0,0,0, 0,0);
    do_reset(e);

    e = mk("rd1234", 1,1,0,0,1,0,0,1, 0,10000);
    apply(1'b0, 16'h1234, e);
    e = mk("rd1238", 2,2,0,1,1,0,0,0, 5000,5000);
    apply(1'b0, 16'h1238, e);
    e = mk("wr2234", 3,2,1,1,2,0,0,1, 3333,6667);
    e.d_way = 2; e.d_idx = 3; e.d_val = 1;
    apply(1'b1, 16'h2234, e);
    e = mk("rd3234", 4,3,1,1,3,1,0,0, 2500,7500);
    e.ev_chk = 1; e.ev_addr = 16'h1230; e.lru_set = 1;
    apply(1'b0, 16'h3234, e);
    e = mk("rd4234", 5,4,1,1,4,2,1,0, 2000,8000);
    e.ev_chk = 1; e.ev_addr = 16'h2230; e.lru_set = 2;
    apply(1'b0, 16'h4234, e);
    e = mk("wr5670", 6,4,2,1,5,2,1,1, 1667,8333);
    apply(1'b1, 16'h5670, e);
    e = mk("wr5670b", 7,4,3,2,5,2,1,0, 2857,7143);
    apply(1'b1, 16'h5670, e);
    e = mk("rd567F", 8,5,3,3,5,2,1,0, 3750,6250);
    e.d_way = 1; e.d_idx = 7; e.d_val = 1;
    apply(1'b0, 16'h567F, e);
    e = mk("rd0000", 9,6,3,3,6,2,1,1, 3333,6667);
    apply(1'b0, 16'h0000, e);
    e = mk("rd1000", 10,7,3,3,7,2,1,1, 3000,7000);
    apply(1'b0, 16'h1000, e);
    e = mk("rd2000", 11,8,3,3,8,3,1,0, 2727,7273);
    e.ev_chk = 1; e.ev_addr = 16'h0000; e.lru_set = 1;
    apply(1'b0, 16'h2000, e);
    e = mk("rd5670", 12,9,3,4,8,3,1,0, 3333,6667);
    e.d_way = 1; e.d_idx = 7; e.d_val = 1;
    apply(1'b0, 16'h5670, e);

    e = mk("reset_mid", 0,0,0,0,0,0,0,0, 0,0);
    e.d_way = 1; e.d_idx = 7; e.d_val = 0;
    do_reset(e);
    e = mk("reset_mid2", 0,0,0,0,0,0,0,0, 0,0);
    do_reset(e);

    e = mk("rd3234r", 1,1,0,0,1,0,0,1, 0,10000);
    apply(1'b0, 16'h3234, e);

    @(negedge clk);
    reset = 1'b1;
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
